// File: rtl/cr_transform.sv
// Nonlinear Cr transform for the skin-tone pipeline: rescales Cr around the
// luma-dependent cluster center outside the luma knees, passes Cr through otherwise.
module cr_transform #(
  parameter logic [7:0]  K_L       = 8'd125,
  parameter logic [7:0]  K_H       = 8'd188,
  parameter logic [15:0] W_CR      = 16'd9923,
  parameter logic [15:0] CENTER_KH = 16'd39424
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  y,
  input  logic [7:0]  cr,
  input  logic [23:0] center_cr,
  input  logic [23:0] width_cr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  cr_out,
  output logic        cr_out_transformed,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t state, next_state;

  logic [7:0]  cr_r;
  logic [23:0] center_r;
  logic [23:0] width_r;
  logic        sign_r;
  logic        num_zero_r;
  logic [31:0] dq_r;
  logic [23:0] rem_r;
  logic [4:0]  cnt_r;

  logic               accept;
  logic               do_transform;
  logic [25:0]        diff;
  logic [25:0]        mag;
  logic [31:0]        prod;
  logic [24:0]        shifted;
  logic               fits;
  logic [23:0]        rem_next;
  logic [31:0]        q_eff;
  logic signed [33:0] q_s;
  logic signed [33:0] sum;
  logic signed [33:0] rounded;
  logic [7:0]         sat;

  assign accept       = in_valid && in_ready;
  assign do_transform = (y <= K_L) || (y >= K_H);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = do_transform ? MUL : DONE;
      MUL:  next_state = DIV;
      DIV:  if (cnt_r == 5'd31) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Signed difference is carried as sign + magnitude so the divider stays unsigned.
  always_comb begin
    diff = {2'b00, cr_r, 8'h00} - {2'b00, center_r};
    mag  = diff[25] ? (26'd0 - diff) : diff;
    prod = {6'b0, mag} * {16'b0, W_CR};
  end

  // One restoring step: shift in the next numerator bit and subtract if it fits.
  // A zero divisor always "fits", which naturally yields an all-ones quotient.
  always_comb begin
    shifted  = {rem_r, dq_r[31]};
    fits     = (shifted >= {1'b0, width_r});
    rem_next = fits ? 24'(shifted - {1'b0, width_r}) : shifted[23:0];
  end

  always_comb begin
    q_eff   = num_zero_r ? 32'd0 : dq_r;
    q_s     = $signed({2'b00, q_eff});
    sum     = $signed({18'b0, CENTER_KH}) + (sign_r ? -q_s : q_s);
    rounded = (sum + 34'sd128) >>> 8;
    if (rounded < 0)             sat = 8'd0;
    else if (rounded > 34'sd255) sat = 8'd255;
    else                         sat = rounded[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cr_r               <= '0;
      center_r           <= '0;
      width_r            <= '0;
      sign_r             <= 1'b0;
      num_zero_r         <= 1'b0;
      dq_r               <= '0;
      rem_r              <= '0;
      cnt_r              <= '0;
      cr_out             <= '0;
      cr_out_transformed <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cr_r     <= cr;
          center_r <= center_cr;
          width_r  <= width_cr;
          if (!do_transform) begin
            cr_out             <= cr;
            cr_out_transformed <= 1'b0;
          end
        end
        MUL: begin
          sign_r     <= diff[25];
          dq_r       <= prod;
          num_zero_r <= (prod == 32'd0);
          rem_r      <= '0;
          cnt_r      <= '0;
        end
        DIV: begin
          dq_r  <= {dq_r[30:0], fits};
          rem_r <= rem_next;
          cnt_r <= cnt_r + 5'd1;
        end
        FIX: begin
          cr_out             <= sat;
          cr_out_transformed <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
